// File: rtl/div3_pkg.sv
// Shared types for the bit-serial divide-by-3 unit: control states and residue codes.
package div3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Residue of the prefix consumed so far, modulo 3. 2'b11 is never produced.
  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;

endpackage

// File: rtl/div3_residue_step.sv
// One MSB-first step of long division by 3: v = 2r + b, r' = v mod 3, q = (v >= 3).
// Purely combinational so it can be replicated in an unrolled variant.
module div3_residue_step
  import div3_pkg::*;
(
  input  logic [1:0] residue,
  input  logic       bit_in,
  output logic [1:0] next_residue,
  output logic       q
);

  // Residue transition table; the unreachable code 2'b11 behaves like R0.
  always_comb begin
    next_residue = R0;
    q            = 1'b0;
    case (residue)
      R1: begin
        next_residue = bit_in ? R0 : R2;
        q            = bit_in;
      end
      R2: begin
        next_residue = bit_in ? R2 : R1;
        q            = 1'b1;
      end
      default: begin
        next_residue = bit_in ? R1 : R0;
        q            = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/div3_serial_divider.sv
// Bit-serial divide-by-3: captures a W-bit operand, walks it MSB-first through the
// residue step one bit per clock, then holds quotient/remainder until consumed.
module div3_serial_divider
  import div3_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [1:0]   remainder,
  output logic         divisible
);

  localparam int CW = $clog2(W);

  state_t         state, state_nxt;
  logic [W-1:0]   shreg;
  logic [W-1:0]   quo;
  logic [1:0]     res;
  logic [CW-1:0]  cnt;
  logic [1:0]     res_nxt;
  logic           qbit;

  div3_residue_step u_step (
    .residue      (res),
    .bit_in       (shreg[W-1]),
    .next_residue (res_nxt),
    .q            (qbit)
  );

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: accept in IDLE, W shift cycles, hold in DONE until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)      state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, then shift operand out and quotient bits in.
  // Residue is forced to R0 on capture, which also scrubs any stray 2'b11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      quo   <= '0;
      res   <= R0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            quo   <= '0;
            res   <= R0;
            cnt   <= CW'(W - 1);
          end
        end
        SHIFT: begin
          shreg <= {shreg[W-2:0], 1'b0};
          quo   <= {quo[W-2:0], qbit};
          res   <= res_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode registered state only; divisible is qualified by DONE
  // so it reads 0 out of reset and during the partial SHIFT phase.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    quotient  = quo;
    remainder = res;
    divisible = (state == DONE) && (res == R0);
  end

endmodule
